bin2bcd_seq: RTL and testbench

Sequential binary-to-packed-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits directly upstream of the 7-segment display controller. Its packed BCD output drives that controller's 32-bit nibble input, so the display shows a decimal value instead of hex. A start/ready/valid handshake lets a register interface or software-visible counter request a conversion.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/bcd_digit_adj.sv | 11 +
 rtl/bin2bcd_seq.sv | 91 +++++++++
 tb/tb_bin2bcd_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, BCD constants and the power-of-ten helper for the seg7 display path
package seg7_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int DIGIT_W = 4;
    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD = 3;
    localparam logic [DIGIT_W-1:0] BCD_NINE = 4'h9;

    // 10^n in 64 bits; exact for n <= 19
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble correction cell, adds 3 to a BCD digit that is 5 or more
module bcd_digit_adj
    import seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    assign q = (d >= DIGIT_W'(BCD_ADJ_THRESH)) ? d + DIGIT_W'(BCD_ADJ_ADD) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary to packed BCD converter, one bit per clock (double dabble)
// Define BIN2BCD_SAT_EN to saturate bcd_o to all nines on overflow.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIGITS = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [DATA_W-1:0]         bin_i,
    output logic                      ready_o,
    output logic                      valid_o,
    output logic [DIGIT_W*DIGITS-1:0] bcd_o,
    output logic                      ovf_o
);

    localparam int BW = DIGIT_W * DIGITS;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CW = (DATA_W > 64) ? DATA_W : 64;
    localparam logic [63:0] LIMIT = pow10(DIGITS);
    // when 10^DIGITS exceeds the largest input, overflow can never happen
    localparam bit OVF_EN = LIMIT <= ((64'd1 << DATA_W) - 64'd1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q;
    logic [BW-1:0]     work_q, work_adj, work_nxt, bcd_load;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_lat_q, ovf_in, accept, last;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d(work_q[DIGIT_W*i +: DIGIT_W]),
            .q(work_adj[DIGIT_W*i +: DIGIT_W])
        );
    end

    assign ready_o  = (state_q == IDLE);
    assign accept   = start_i & ready_o;
    assign last     = (state_q == SHIFT) && (cnt_q == '0);
    assign work_nxt = {work_adj[BW-2:0], shift_q[DATA_W-1]};
    assign ovf_in   = OVF_EN && (CW'(bin_i) >= CW'(LIMIT));

`ifdef BIN2BCD_SAT_EN
    assign bcd_load = ovf_lat_q ? {DIGITS{BCD_NINE}} : work_nxt;
`else
    assign bcd_load = work_nxt;
`endif

    // next state: leave IDLE on an accepted start, return after the last shift
    always_comb begin
        state_d = accept ? SHIFT : (last ? IDLE : state_q);
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // datapath: load on accept, adjust-and-shift while converting, publish on the last shift
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            ovf_lat_q <= 1'b0;
            bcd_o     <= '0;
            ovf_o     <= 1'b0;
            valid_o   <= 1'b0;
        end else begin
            valid_o <= last;
            if (accept) begin
                shift_q   <= bin_i;
                work_q    <= '0;
                cnt_q     <= CNT_W'(DATA_W - 1);
                ovf_lat_q <= ovf_in;
            end else if (state_q == SHIFT) begin
                shift_q <= shift_q << 1;
                work_q  <= work_nxt;
                cnt_q   <= cnt_q - 1'b1;
            end
            if (last) begin
                bcd_o <= bcd_load;
                ovf_o <= ovf_lat_q;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

    logic        clk_i = 1'b0;
    logic        rst_n, start_i, ready_o, valid_o, ovf_o;
    logic [31:0] bin_i, bcd_o;
    int          errors = 0;
    int          checks = 0;
    int          n, c;
    logic [31:0] exp_ovf_a, exp_ovf_b;

    always #5 clk_i = ~clk_i;

    bin2bcd_seq #(.DATA_W(32), .DIGITS(8)) dut (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .start_i(start_i),
        .bin_i(bin_i),
        .ready_o(ready_o),
        .valid_o(valid_o),
        .bcd_o(bcd_o),
        .ovf_o(ovf_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [31:0] v);
        bin_i   = v;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk_i);
            #1;
            cyc++;
        end while (!valid_o && cyc < 40);
    endtask

    task automatic count_valid(input int len, output int cnt);
        cnt = 0;
        for (int i = 0; i < len; i++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) cnt++;
        end
    endtask

    initial begin
`ifdef BIN2BCD_SAT_EN
        exp_ovf_a = 32'h99999999;
        exp_ovf_b = 32'h99999999;
`else
        exp_ovf_a = 32'h00000000;
        exp_ovf_b = 32'h94967295;
`endif
        rst_n = 1'b0; start_i = 1'b0; bin_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_bcd", bcd_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 1);
        @(negedge clk_i) rst_n = 1'b1;
        @(negedge clk_i);

        go(32'd0);
        chk("zero_busy", ready_o, 0);
        wait_valid(n);
        chk("zero_lat", n, 32);
        chk("zero_bcd", bcd_o, 32'h0);
        chk("zero_ovf", ovf_o, 0);
        chk("zero_ready", ready_o, 1);
        @(posedge clk_i); #1;
        chk("zero_pulse", valid_o, 0);
        chk("idle_ready", ready_o, 1);

        go(32'd12345678);
        wait_valid(n);
        chk("b2b1_lat", n, 32);
        chk("b2b1_bcd", bcd_o, 32'h12345678);
        chk("b2b1_ovf", ovf_o, 0);
        chk("b2b1_ready", ready_o, 1);
        go(32'd99999999);
        chk("b2b1_pulse", valid_o, 0);
        chk("b2b1_hold", bcd_o, 32'h12345678);
        wait_valid(n);
        chk("b2b2_gap", n, 32);
        chk("b2b2_bcd", bcd_o, 32'h99999999);
        chk("b2b2_ovf", ovf_o, 0);
        @(negedge clk_i);

        go(32'd100000000);
        wait_valid(n);
        chk("e8_lat", n, 32);
        chk("e8_bcd", bcd_o, exp_ovf_a);
        chk("e8_ovf", ovf_o, 1);
        @(negedge clk_i);

        go(32'hFFFFFFFF);
        wait_valid(n);
        chk("max_lat", n, 32);
        chk("max_bcd", bcd_o, exp_ovf_b);
        chk("max_ovf", ovf_o, 1);
        @(negedge clk_i);

        go(32'd1234);
        repeat (9) @(posedge clk_i);
        #1;
        chk("busy_ready", ready_o, 0);
        go(32'd5678);
        bin_i = 32'd9999;
        wait_valid(n);
        chk("ign_lat", n, 22);
        chk("ign_bcd", bcd_o, 32'h00001234);
        chk("ign_ovf", ovf_o, 0);
        count_valid(40, c);
        chk("ign_novalid", c, 0);
        chk("ign_hold", bcd_o, 32'h00001234);

        @(negedge clk_i);
        go(32'd777);
        repeat (14) @(posedge clk_i);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_bcd", bcd_o, 0);
        chk("abort_ovf", ovf_o, 0);
        chk("abort_valid", valid_o, 0);
        chk("abort_ready", ready_o, 1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_n = 1'b1;
        count_valid(40, c);
        chk("abort_novalid", c, 0);
        chk("abort_bcd2", bcd_o, 0);
        @(negedge clk_i);
        go(32'd42);
        wait_valid(n);
        chk("post_lat", n, 32);
        chk("post_bcd", bcd_o, 32'h00000042);
        chk("post_ovf", ovf_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
